inmp441_mic_i2s_emulator: RTL

- Transmit-side counterpart of the INMP441 I2S microphone receiver.
- Acts as an I2S slave: takes SCK/WS from an external master (the receiver or board logic) and shifts 24-bit samples out on SD.
- Used for loopback on GPIO pins and for benches that exercise the receiver without a real microphone.
- Runs on the fabric clock; SCK and WS are oversampled, not used as clocks.

---
 rtl/inmp441_mic_i2s_emulator_pkg.sv | 7 +
 rtl/inmp441_mic_i2s_emulator_sync_edge_detect.sv | 18 +
 rtl/inmp441_mic_i2s_emulator.sv | 151 +++++++++++++++
 3 files changed

// File: rtl/inmp441_mic_i2s_emulator_pkg.sv
// Shared I2S definitions for the INMP441 emulator and the receiver bench.
package i2s_pkg;
   localparam int w_i2s_sample = 24;
   localparam int w_i2s_slot   = 32;

   typedef enum logic [1:0] {IDLE, ARM, SHIFT} i2s_tx_state_t;
endpackage

// File: rtl/inmp441_mic_i2s_emulator_sync_edge_detect.sv
// Two-flop synchronizer with registered history for rise/fall pulse detection.
module sync_edge_detect (
   input  logic clk,
   input  logic rst,
   input  logic din,
   output logic rise,
   output logic fall
);
   logic [2:0] sr;

   always_ff @(posedge clk) begin
      if (rst) sr <= '0;
      else     sr <= {sr[1:0], din};
   end

   assign rise = sr[1] & ~sr[2];
   assign fall = ~sr[1] & sr[2];
endmodule

// File: rtl/inmp441_mic_i2s_emulator.sv
// I2S slave transmitter emulating an INMP441 microphone on oversampled SCK/WS.
// Define INMP441_EMU_TEST_PATTERN_EN to replace the sample input with a sawtooth.
//
// state | meaning
// IDLE  | SD released, waiting for the WS edge into our slot
// ARM   | slot started, skipping the one-bit I2S delay
// SHIFT | driving sample bits MSB first on SCK falls
module inmp441_mic_i2s_emulator
   import i2s_pkg::*;
#(
   parameter int                  w_sample     = w_i2s_sample,
   parameter logic [w_sample-1:0] pattern_step = 24'h000400
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                sck,
   input  logic                ws,
   input  logic                lr,
   input  logic [w_sample-1:0] sample,
   input  logic                sample_valid,
   output logic                sample_ready,
   output logic                sd,
   output logic                sd_oe,
   output logic                underrun,
   output logic                frame_err
);
   localparam int                w_cnt    = $clog2(w_sample + 1);
   localparam logic [w_cnt-1:0] cnt_last = w_cnt'(w_sample);

   i2s_tx_state_t       state, state_nxt;
   logic [w_sample-1:0] shreg, shreg_nxt, load_val;
   logic [w_cnt-1:0]    cnt, cnt_nxt;
   logic                sd_nxt, sd_oe_nxt, frame_err_nxt, load;
   logic                sck_rise, sck_fall, ws_rise, ws_fall, ws_edge, slot_start;
   logic                unused_sck_rise;

   sync_edge_detect u_sync_sck (.clk(clk), .rst(rst), .din(sck), .rise(sck_rise), .fall(sck_fall));
   sync_edge_detect u_sync_ws  (.clk(clk), .rst(rst), .din(ws),  .rise(ws_rise),  .fall(ws_fall));

   assign unused_sck_rise = sck_rise;
   assign ws_edge    = ws_rise | ws_fall;
   assign slot_start = lr ? ws_rise : ws_fall;

`ifdef INMP441_EMU_TEST_PATTERN_EN
   logic [w_sample-1:0] pattern;
   logic                unused_sample;

   assign unused_sample = ^{sample, sample_valid};
   assign sample_ready  = 1'b0;
   assign underrun      = 1'b0;
   assign load_val      = pattern;

   always_ff @(posedge clk) begin
      if (rst)       pattern <= '0;
      else if (load) pattern <= pattern + pattern_step;
   end
`else
   logic                held, accept;
   logic [w_sample-1:0] hold_reg, last_reg;

   assign sample_ready = !held;
   assign accept       = sample_valid && !held;
   assign load_val     = held ? hold_reg : last_reg;

   // A transfer coinciding with slot start lands in the holding register for the next frame.
   always_ff @(posedge clk) begin
      if (rst) begin
         held     <= 1'b0;
         hold_reg <= '0;
         last_reg <= '0;
         underrun <= 1'b0;
      end else begin
         underrun <= load && !held;
         if (load && held) last_reg <= hold_reg;
         held <= (held && !load) || accept;
         if (accept) hold_reg <= sample;
      end
   end
`endif

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= IDLE;
         shreg     <= '0;
         cnt       <= '0;
         sd        <= 1'b0;
         sd_oe     <= 1'b0;
         frame_err <= 1'b0;
      end else begin
         state     <= state_nxt;
         shreg     <= shreg_nxt;
         cnt       <= cnt_nxt;
         sd        <= sd_nxt;
         sd_oe     <= sd_oe_nxt;
         frame_err <= frame_err_nxt;
      end
   end

   // A WS edge outranks an SCK fall seen in the same cycle.
   always_comb begin
      state_nxt     = state;
      shreg_nxt     = shreg;
      cnt_nxt       = cnt;
      sd_nxt        = sd;
      sd_oe_nxt     = sd_oe;
      frame_err_nxt = 1'b0;
      load          = 1'b0;
      case (state)
         IDLE: begin
            sd_oe_nxt = 1'b0;
            if (slot_start) begin
               load      = 1'b1;
               shreg_nxt = load_val;
               state_nxt = ARM;
            end
         end
         ARM: begin
            if (ws_edge) begin
               sd_nxt        = 1'b0;
               sd_oe_nxt     = 1'b0;
               frame_err_nxt = 1'b1;
               state_nxt     = IDLE;
            end else if (sck_fall) begin
               sd_nxt    = shreg[w_sample-1];
               sd_oe_nxt = 1'b1;
               cnt_nxt   = w_cnt'(1);
               state_nxt = SHIFT;
            end
         end
         SHIFT: begin
            if (ws_edge) begin
               sd_nxt        = 1'b0;
               sd_oe_nxt     = 1'b0;
               frame_err_nxt = 1'b1;
               state_nxt     = IDLE;
            end else if (sck_fall) begin
               if (cnt == cnt_last) begin
                  sd_nxt    = 1'b0;
                  sd_oe_nxt = 1'b0;
                  state_nxt = IDLE;
               end else begin
                  shreg_nxt = shreg << 1;
                  sd_nxt    = shreg[w_sample-2];
                  cnt_nxt   = cnt + 1'b1;
               end
            end
         end
         default: state_nxt = IDLE;
      endcase
   end
endmodule
